// File: rtl/regfile_check_pkg.sv
// rtl/regfile_check_pkg.sv - shared state encoding, entry layout and defaults for the register-file result checker
package regfile_check_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_WAIT  = ST_WAIT,
    S_CHECK = ST_CHECK,
    S_DONE  = ST_DONE
  } state_t;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_NCHECK  = 8;
  localparam int DEF_TIMEOUT = 50000;

  // Default-width table entry: register index plus expected value.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_WIDTH-1:0]  data;
  } entry_t;

endpackage

// File: rtl/check_table.sv
// rtl/check_table.sv - NCHECK-entry expectation table, sync write/clear, combinational read (mask field under CHECK_MASK_EN)
module check_table #(
  parameter  int WIDTH  = 32,
  parameter  int ADDR_W = 5,
  parameter  int NCHECK = 8,
  localparam int IDX_W  = (NCHECK > 1) ? $clog2(NCHECK) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
`ifdef CHECK_MASK_EN
  input  logic [WIDTH-1:0]  wmask_i,
  output logic [WIDTH-1:0]  rmask_o,
`endif
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [ADDR_W-1:0] raddr_o,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [ADDR_W-1:0] addr_q [NCHECK];
  logic [WIDTH-1:0]  data_q [NCHECK];
`ifdef CHECK_MASK_EN
  logic [WIDTH-1:0]  mask_q [NCHECK];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCHECK; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
`ifdef CHECK_MASK_EN
        mask_q[i] <= '1;
`endif
      end
    end else if (we_i && (int'(widx_i) < NCHECK)) begin
      addr_q[widx_i] <= waddr_i;
      data_q[widx_i] <= wdata_i;
`ifdef CHECK_MASK_EN
      mask_q[widx_i] <= wmask_i;
`endif
    end
  end

  assign raddr_o = addr_q[ridx_i];
  assign rdata_o = data_q[ridx_i];
`ifdef CHECK_MASK_EN
  assign rmask_o = mask_q[ridx_i];
`endif

endmodule

// File: rtl/regfile_result_checker.sv
// rtl/regfile_result_checker.sv - waits for CPU halt or timeout, then compares the register file against the table
// Optional masked compare and exp_mask port enabled by CHECK_MASK_EN.
module regfile_result_checker
  import regfile_check_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int ADDR_W  = DEF_ADDR_W,
  parameter  int NCHECK  = DEF_NCHECK,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int IDX_W   = (NCHECK > 1) ? $clog2(NCHECK) : 1,
  localparam int FCNT_W  = $clog2(NCHECK + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [WIDTH-1:0]  exp_data,
`ifdef CHECK_MASK_EN
  input  logic [WIDTH-1:0]  exp_mask,
`endif
  input  logic              start,
  input  logic              halt,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [FCNT_W-1:0] fail_count,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [WIDTH-1:0]  fail_actual
);

  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NCHECK - 1);

  state_t            state_q, state_d;
  logic [TCNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d, to_q, to_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;
  logic [WIDTH-1:0]  fact_q, fact_d;

  logic [ADDR_W-1:0] t_addr;
  logic [WIDTH-1:0]  t_data;
  logic              mismatch;
  logic              tbl_we;

  // Table is frozen while a run is in flight so the check sees a stable snapshot.
  assign tbl_we = exp_we && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef CHECK_MASK_EN
  logic [WIDTH-1:0] t_mask;
`endif

  check_table #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .NCHECK (NCHECK)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .we_i    (tbl_we),
    .widx_i  (exp_idx),
    .waddr_i (exp_addr),
    .wdata_i (exp_data),
`ifdef CHECK_MASK_EN
    .wmask_i (exp_mask),
    .rmask_o (t_mask),
`endif
    .ridx_i  (idx_q),
    .raddr_o (t_addr),
    .rdata_o (t_data)
  );

`ifdef CHECK_MASK_EN
  assign mismatch = |((rd_data ^ t_data) & t_mask);
`else
  assign mismatch = (rd_data != t_data);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
      fcnt_q  <= '0;
      fidx_q  <= '0;
      fact_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
      fcnt_q  <= fcnt_d;
      fidx_q  <= fidx_d;
      fact_q  <= fact_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    to_d    = to_q;
    fcnt_d  = fcnt_q;
    fidx_d  = fidx_q;
    fact_d  = fact_q;
    rd_addr = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          to_d    = 1'b0;
          fcnt_d  = '0;
          fidx_d  = '0;
          fact_d  = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + TCNT_W'(1);
        // Halt takes priority over a timeout landing in the same cycle.
        if (halt) begin
          state_d = S_CHECK;
          idx_d   = '0;
        end else if (cnt_q == TCNT_LAST) begin
          to_d    = 1'b1;
          state_d = S_CHECK;
          idx_d   = '0;
        end
      end
      S_CHECK: begin
        rd_addr = t_addr;
        if (mismatch) begin
          fcnt_d = fcnt_q + FCNT_W'(1);
          if (fcnt_q == '0) begin
            fidx_d = idx_q;
            fact_d = rd_data;
          end
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fcnt_d == '0) && !to_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timed_out   = to_q;
  assign fail_count  = fcnt_q;
  assign fail_idx    = fidx_q;
  assign fail_actual = fact_q;

endmodule
